// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : RV64 memory-access stage. Single-outstanding dmem port,
//   load extension, ready/valid on both sides. Optional MEM_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int XLEN         = 64,
  parameter int OP_WIDTH     = 12,
  parameter int OP_LOAD_BIT  = 1,
  parameter int OP_STORE_BIT = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                E_valid_i,
  output logic                M_ready_o,
  input  logic [XLEN-1:0]     E_valE_i,
  input  logic [XLEN-1:0]     D_rs2_data_i,
  input  logic [OP_WIDTH-1:0] F_epcode_i,
  input  logic [2:0]          F_mem_op_i,
  output logic                M_valid_o,
  input  logic                W_ready_i,
  output logic [XLEN-1:0]     M_valM_o,
  output logic                M_misalign_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  output logic [7:0]          dmem_wstrb_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i
);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3} state_t;

  state_t          state_q;
  logic            valid_q;
  logic [XLEN-1:0] valM_q;
  logic            req_q;
  logic            we_q;
  logic            is_load_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic [2:0]      funct3_q;

  logic            is_load;
  logic            is_store;
  logic            mem_op;
  logic            misaligned;
  logic [2:0]      low_mask;
  logic [XLEN-1:0] addr_eff;
  logic            accept;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] store_rep;
  logic [7:0]      strobe_base;
  logic            w_unused;

  assign is_load  = F_epcode_i[OP_LOAD_BIT];
  assign is_store = F_epcode_i[OP_STORE_BIT];
  assign mem_op   = is_load | is_store;
  assign w_unused = ^F_epcode_i;

  always_comb begin
    low_mask   = 3'b000;
    misaligned = 1'b0;
    case (F_mem_op_i[1:0])
      2'b01:   begin low_mask = 3'b001; misaligned = E_valE_i[0]; end
      2'b10:   begin low_mask = 3'b011; misaligned = |E_valE_i[1:0]; end
      2'b11:   begin low_mask = 3'b111; misaligned = |E_valE_i[2:0]; end
      default: begin low_mask = 3'b000; misaligned = 1'b0; end
    endcase
  end

  // Without the trap, misaligned accesses are forced down to size alignment.
  assign addr_eff = {E_valE_i[XLEN-1:3], E_valE_i[2:0] & ~low_mask};

  assign M_ready_o = (state_q == S_IDLE) || ((state_q == S_DONE) && W_ready_i);
  assign accept    = E_valid_i && M_ready_o;

  assign lane = dmem_rdata_i >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){lane[7]}},   lane[7:0]};
      3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}},      lane[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}},     lane[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}},     lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    store_rep   = data_q;
    strobe_base = 8'hFF;
    case (funct3_q[1:0])
      2'b00:   begin store_rep = {8{data_q[7:0]}};  strobe_base = 8'h01; end
      2'b01:   begin store_rep = {4{data_q[15:0]}}; strobe_base = 8'h03; end
      2'b10:   begin store_rep = {2{data_q[31:0]}}; strobe_base = 8'h0F; end
      default: begin store_rep = data_q;            strobe_base = 8'hFF; end
    endcase
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[XLEN-1:3], 3'b000};
  assign dmem_wdata_o = store_rep << {addr_q[2:0], 3'b000};
  assign dmem_wstrb_o = we_q ? (strobe_base << addr_q[2:0]) : 8'h00;
  assign M_valid_o    = valid_q;
  assign M_valM_o     = valM_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      valM_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      funct3_q  <= 3'b000;
    end else if (accept) begin
      if (mem_op && !(TRAP_EN && misaligned)) begin
        state_q   <= S_REQ;
        valid_q   <= 1'b0;
        req_q     <= 1'b1;
        we_q      <= !is_load;
        is_load_q <= is_load;
        addr_q    <= addr_eff;
        data_q    <= D_rs2_data_i;
        funct3_q  <= F_mem_op_i;
      end else begin
        state_q <= S_DONE;
        valid_q <= 1'b1;
        valM_q  <= E_valE_i;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (dmem_gnt_i) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (is_load_q) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              valM_q  <= '0;
            end
          end
        end
        S_RESP: begin
          if (dmem_rvalid_i) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            valM_q  <= load_ext;
          end
        end
        S_DONE: begin
          if (W_ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;

  // Only a trapped access ever sets the flag, and it goes straight to DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= mem_op && misaligned;
    end
  end

  assign M_misalign_o = misalign_q;
`else
  assign M_misalign_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed self-checking bench for mem_access_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
  localparam int XLEN = 64;
  localparam int OPW  = 12;
  localparam logic [OPW-1:0] OP_ADD   = 12'h001;
  localparam logic [OPW-1:0] OP_LOAD  = 12'h002;
  localparam logic [OPW-1:0] OP_STORE = 12'h004;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            E_valid_i;
  logic            M_ready_o;
  logic [XLEN-1:0] E_valE_i;
  logic [XLEN-1:0] D_rs2_data_i;
  logic [OPW-1:0]  F_epcode_i;
  logic [2:0]      F_mem_op_i;
  logic            M_valid_o;
  logic            W_ready_i;
  logic [XLEN-1:0] M_valM_o;
  logic            M_misalign_o;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic [7:0]      dmem_wstrb_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.XLEN(XLEN), .OP_WIDTH(OPW), .OP_LOAD_BIT(1), .OP_STORE_BIT(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .E_valid_i(E_valid_i), .M_ready_o(M_ready_o),
    .E_valE_i(E_valE_i), .D_rs2_data_i(D_rs2_data_i),
    .F_epcode_i(F_epcode_i), .F_mem_op_i(F_mem_op_i),
    .M_valid_o(M_valid_o), .W_ready_i(W_ready_i),
    .M_valM_o(M_valM_o), .M_misalign_o(M_misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_wstrb_o(dmem_wstrb_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [OPW-1:0] op, input logic [2:0] f3,
                       input logic [XLEN-1:0] vale, input logic [XLEN-1:0] rs2);
    E_valid_i    = 1'b1;
    F_epcode_i   = op;
    F_mem_op_i   = f3;
    E_valE_i     = vale;
    D_rs2_data_i = rs2;
  endtask

  initial begin
    rst_i = 1'b1; E_valid_i = 1'b0; E_valE_i = '0; D_rs2_data_i = '0;
    F_epcode_i = '0; F_mem_op_i = 3'b000; W_ready_i = 1'b1;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    tick; tick;
    chk("rst_valid", 64'(M_valid_o), 64'd0);
    chk("rst_valM", M_valM_o, 64'd0);
    chk("rst_misalign", 64'(M_misalign_o), 64'd0);
    chk("rst_dmem", {dmem_addr_o[31:0], 22'd0, dmem_wstrb_o, dmem_we_o, dmem_req_o}, 64'd0);
    chk("rst_wdata", dmem_wdata_o, 64'd0);
    rst_i = 1'b0; #1;
    chk("rst_ready", 64'(M_ready_o), 64'd1);

    // ADD passthrough
    issue(OP_ADD, 3'b000, 64'h1234, 64'h0);
    tick;
    E_valid_i = 1'b0;
    chk("add_valid", 64'(M_valid_o), 64'd1);
    chk("add_valM", M_valM_o, 64'h1234);
    chk("add_noreq", 64'(dmem_req_o), 64'd0);
    tick;
    chk("add_idle", 64'(M_valid_o), 64'd0);

    // back-to-back passthrough
    issue(OP_ADD, 3'b000, 64'h1, 64'h0);
    tick;
    chk("b2b_1", M_valM_o, 64'h1);
    E_valE_i = 64'h2;
    tick;
    E_valid_i = 1'b0;
    chk("b2b_2v", 64'(M_valid_o), 64'd1);
    chk("b2b_2", M_valM_o, 64'h2);
    tick;

    // LB at 0x1003, zero-wait
    issue(OP_LOAD, 3'b000, 64'h1003, 64'h0);
    tick;
    E_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    chk("lb_req", 64'(dmem_req_o), 64'd1);
    chk("lb_we", 64'(dmem_we_o), 64'd0);
    chk("lb_addr", dmem_addr_o, 64'h1000);
    chk("lb_novalid", 64'(M_valid_o), 64'd0);
    tick;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h00000000_80000000;
    chk("lb_req_drop", 64'(dmem_req_o), 64'd0);
    tick;
    dmem_rvalid_i = 1'b0;
    chk("lb_valid", 64'(M_valid_o), 64'd1);
    chk("lb_valM", M_valM_o, 64'hFFFFFFFF_FFFFFF80);
    tick;

    // LBU at 0x1003
    issue(OP_LOAD, 3'b100, 64'h1003, 64'h0);
    tick;
    E_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1;
    tick;
    dmem_rvalid_i = 1'b0;
    chk("lbu_valM", M_valM_o, 64'h80);
    tick;

    // SH at 0x2006, grant after three request cycles
    issue(OP_STORE, 3'b001, 64'h2006, 64'hABCD);
    tick;
    E_valid_i = 1'b0;
    chk("sh_req1", 64'(dmem_req_o), 64'd1);
    chk("sh_we", 64'(dmem_we_o), 64'd1);
    chk("sh_wstrb", 64'(dmem_wstrb_o), 64'hC0);
    chk("sh_wdata", dmem_wdata_o, 64'hABCD0000_00000000);
    chk("sh_addr", dmem_addr_o, 64'h2000);
    tick;
    chk("sh_req2", 64'(dmem_req_o), 64'd1);
    tick;
    chk("sh_req3", {dmem_wdata_o[63:48], 39'd0, dmem_wstrb_o, dmem_req_o}, {16'hABCD, 39'd0, 8'hC0, 1'b1});
    dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0;
    chk("sh_valid", 64'(M_valid_o), 64'd1);
    chk("sh_valM", M_valM_o, 64'd0);
    chk("sh_req_drop", 64'(dmem_req_o), 64'd0);
    tick;

    // SB at 0x5005, zero-wait: result at g+1
    issue(OP_STORE, 3'b000, 64'h5005, 64'h1234_565A);
    tick;
    E_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    chk("sb_wstrb", 64'(dmem_wstrb_o), 64'h20);
    chk("sb_wdata", dmem_wdata_o, 64'h5A5A5A00_00000000);
    tick;
    dmem_gnt_i = 1'b0;
    chk("sb_valid", 64'(M_valid_o), 64'd1);
    tick;

    // LW at 0x4004 with writeback stalled; stray rvalid/gnt and a pending ADD
    issue(OP_LOAD, 3'b010, 64'h4004, 64'h0);
    tick;
    E_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h8899AABB_00000000;
    W_ready_i = 1'b0;
    tick;
    dmem_rdata_i = 64'h0123_4567_89AB_CDEF; dmem_gnt_i = 1'b1;
    issue(OP_ADD, 3'b000, 64'h55, 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("lw_stall_valid", 64'(M_valid_o), 64'd1);
      chk("lw_stall_valM", M_valM_o, 64'hFFFFFFFF_8899AABB);
      chk("lw_stall_ready", 64'(M_ready_o), 64'd0);
      tick;
    end
    dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
    chk("lw_stall_noreq", 64'(dmem_req_o), 64'd0);
    W_ready_i = 1'b1;
    tick;
    E_valid_i = 1'b0;
    chk("lw_b2b_valid", 64'(M_valid_o), 64'd1);
    chk("lw_b2b_valM", M_valM_o, 64'h55);
    tick;

    // LD at 0x3004 (misaligned)
    issue(OP_LOAD, 3'b011, 64'h3004, 64'h0);
    tick;
    E_valid_i = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("ld_mis_flag", 64'(M_misalign_o), 64'd1);
    chk("ld_mis_valM", M_valM_o, 64'h3004);
    chk("ld_mis_noreq", 64'(dmem_req_o), 64'd0);
    chk("ld_mis_valid", 64'(M_valid_o), 64'd1);
    tick;
`else
    chk("ld_mis_flag", 64'(M_misalign_o), 64'd0);
    chk("ld_mis_req", 64'(dmem_req_o), 64'd1);
    chk("ld_mis_addr", dmem_addr_o, 64'h3000);
    dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEADBEEF_CAFEF00D;
    tick;
    dmem_rvalid_i = 1'b0;
    chk("ld_mis_valM", M_valM_o, 64'hDEADBEEF_CAFEF00D);
    tick;
`endif

    // reset while waiting for a response
    issue(OP_LOAD, 3'b011, 64'h10, 64'h0);
    tick;
    E_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1; #1;
    chk("mrst_outs", {M_valM_o[31:0], 22'd0, dmem_wstrb_o, M_valid_o, dmem_req_o}, 64'd0);
    chk("mrst_addr", dmem_addr_o, 64'd0);
    tick;
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    dmem_rvalid_i = 1'b0;
    chk("mrst_ignored_valid", 64'(M_valid_o), 64'd0);
    chk("mrst_ignored_valM", M_valM_o, 64'd0);
    chk("mrst_ready", 64'(M_ready_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
